// File: rtl/rename_pkg.sv
// ---------------------------------------------------------------------------
// rename_pkg
// Shared types and helpers for the N-wide register-rename stage.
//   arch_idx_t / phys_idx_t : architectural / physical register indices at the
//                              default sizing (32 arch regs, 64 phys regs)
//   renamed_slot_t          : one renamed slot as presented to IQ/LSQ/ROB
//   rn_clog2()              : constant-foldable ceil(log2) for port sizing
// ---------------------------------------------------------------------------
package rename_pkg;

  localparam int LOG_ARCH_DEF = 5;
  localparam int LOG_PHYS_DEF = 6;

  typedef logic [LOG_ARCH_DEF-1:0] arch_idx_t;
  typedef logic [LOG_PHYS_DEF-1:0] phys_idx_t;

  typedef struct packed {
    logic      valid;
    phys_idx_t src_a;
    logic      rdy_a;
    phys_idx_t src_b;
    logic      rdy_b;
    logic      dst_en;
    phys_idx_t dst;
    phys_idx_t old;
  } renamed_slot_t;

  // ceil(log2(value)); returns 0 for value <= 1
  function automatic int rn_clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (rem > 0) begin
        result = result + 1;
        rem    = rem >> 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/rename_dep_check.sv
// ---------------------------------------------------------------------------
// rename_dep_check
// Combinational intra-bundle dependency network. For every slot j it finds the
// highest-index earlier accepted slot i < j that allocates a destination equal
// to j's srcA / srcB / dst, and returns that slot's new physical register.
//   acc_mask   : slots accepted this cycle (contiguous prefix)
//   need_mask  : slots that allocate a destination
//   dst_arch, src_a_arch, src_b_arch : per-slot arch indices
//   new_phys   : per-slot newly allocated physical register
//   hit_*      : an earlier in-bundle producer exists
//   byp_*      : that producer's new physical register
// ---------------------------------------------------------------------------
module rename_dep_check #(
  parameter int WIDTH    = 2,
  parameter int LOG_ARCH = 5,
  parameter int LOG_PHYS = 6
) (
  input  logic [WIDTH-1:0]          acc_mask,
  input  logic [WIDTH-1:0]          need_mask,
  input  logic [WIDTH*LOG_ARCH-1:0] dst_arch,
  input  logic [WIDTH*LOG_ARCH-1:0] src_a_arch,
  input  logic [WIDTH*LOG_ARCH-1:0] src_b_arch,
  input  logic [WIDTH*LOG_PHYS-1:0] new_phys,
  output logic [WIDTH-1:0]          hit_a,
  output logic [WIDTH-1:0]          hit_b,
  output logic [WIDTH-1:0]          hit_old,
  output logic [WIDTH*LOG_PHYS-1:0] byp_a,
  output logic [WIDTH*LOG_PHYS-1:0] byp_b,
  output logic [WIDTH*LOG_PHYS-1:0] byp_old
);

  // Priority scan: iterating i upward lets the youngest earlier producer win.
  always_comb begin
    logic prod_s;
    logic match_a_s;
    logic match_b_s;
    logic match_o_s;
    hit_a     = {WIDTH{1'b0}};
    hit_b     = {WIDTH{1'b0}};
    hit_old   = {WIDTH{1'b0}};
    byp_a     = {(WIDTH*LOG_PHYS){1'b0}};
    byp_b     = {(WIDTH*LOG_PHYS){1'b0}};
    byp_old   = {(WIDTH*LOG_PHYS){1'b0}};
    prod_s    = 1'b0;
    match_a_s = 1'b0;
    match_b_s = 1'b0;
    match_o_s = 1'b0;
    for (int j = 1; j < WIDTH; j++) begin
      for (int i = 0; i < j; i++) begin
        prod_s    = acc_mask[i] & need_mask[i];
        match_a_s = prod_s & (dst_arch[i*LOG_ARCH +: LOG_ARCH] == src_a_arch[j*LOG_ARCH +: LOG_ARCH]);
        match_b_s = prod_s & (dst_arch[i*LOG_ARCH +: LOG_ARCH] == src_b_arch[j*LOG_ARCH +: LOG_ARCH]);
        match_o_s = prod_s & (dst_arch[i*LOG_ARCH +: LOG_ARCH] == dst_arch[j*LOG_ARCH +: LOG_ARCH]);
        hit_a[j]   = hit_a[j] | match_a_s;
        hit_b[j]   = hit_b[j] | match_b_s;
        hit_old[j] = hit_old[j] | match_o_s;
        byp_a[j*LOG_PHYS +: LOG_PHYS]   = match_a_s ? new_phys[i*LOG_PHYS +: LOG_PHYS]
                                                    : byp_a[j*LOG_PHYS +: LOG_PHYS];
        byp_b[j*LOG_PHYS +: LOG_PHYS]   = match_b_s ? new_phys[i*LOG_PHYS +: LOG_PHYS]
                                                    : byp_b[j*LOG_PHYS +: LOG_PHYS];
        byp_old[j*LOG_PHYS +: LOG_PHYS] = match_o_s ? new_phys[i*LOG_PHYS +: LOG_PHYS]
                                                    : byp_old[j*LOG_PHYS +: LOG_PHYS];
      end
    end
  end

endmodule

// File: rtl/rename_nwide.sv
// ---------------------------------------------------------------------------
// rename_nwide
// WIDTH-wide register-rename stage between the decode FIFO and IQ/LSQ/ROB.
// Owns the speculative F-RAT and the physical busy table. Each cycle renames
// the longest in-order prefix of the offered bundle that downstream resources
// can take; FLUSH restores the F-RAT from the committed map.
// Ports:
//   CLK, RESET (async, active-low), FLUSH
//   Commit_map                         committed map, slot i at [i*LOG_PHYS +: LOG_PHYS]
//   In_valid/In_dst/In_srcA/In_srcB/In_regwrite/In_mem   offered bundle
//   Free_phys                          next WIDTH free-list heads, in order
//   Free_count/Rob_free/Iq_free/Lsq_free  downstream capacity
//   Wb_valid/Wb_phys                   writeback broadcasts (clear busy)
//   Accept_count, Free_pop_count       combinational pop counts
//   Out_*                              registered renamed bundle (1-cycle latency)
// ---------------------------------------------------------------------------
module rename_nwide
  import rename_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int LOG_ARCH = 5,
  parameter int LOG_PHYS = 6,
  parameter int NWB      = 2,
  parameter int CNT_BITS = 4
) (
  input  logic                                   CLK,
  input  logic                                   RESET,
  input  logic                                   FLUSH,
  input  logic [(2**LOG_ARCH)*LOG_PHYS-1:0]      Commit_map,
  input  logic [WIDTH-1:0]                       In_valid,
  input  logic [WIDTH*LOG_ARCH-1:0]              In_dst,
  input  logic [WIDTH*LOG_ARCH-1:0]              In_srcA,
  input  logic [WIDTH*LOG_ARCH-1:0]              In_srcB,
  input  logic [WIDTH-1:0]                       In_regwrite,
  input  logic [WIDTH-1:0]                       In_mem,
  input  logic [WIDTH*LOG_PHYS-1:0]              Free_phys,
  input  logic [CNT_BITS-1:0]                    Free_count,
  input  logic [CNT_BITS-1:0]                    Rob_free,
  input  logic [CNT_BITS-1:0]                    Iq_free,
  input  logic [CNT_BITS-1:0]                    Lsq_free,
  input  logic [NWB-1:0]                         Wb_valid,
  input  logic [NWB*LOG_PHYS-1:0]                Wb_phys,
  output logic [rn_clog2(WIDTH+1)-1:0]           Accept_count,
  output logic [rn_clog2(WIDTH+1)-1:0]           Free_pop_count,
  output logic [WIDTH-1:0]                       Out_valid,
  output logic [WIDTH*LOG_PHYS-1:0]              Out_srcA_phys,
  output logic [WIDTH*LOG_PHYS-1:0]              Out_srcB_phys,
  output logic [WIDTH-1:0]                       Out_srcA_rdy,
  output logic [WIDTH-1:0]                       Out_srcB_rdy,
  output logic [WIDTH*LOG_PHYS-1:0]              Out_dst_phys,
  output logic [WIDTH*LOG_PHYS-1:0]              Out_old_phys,
  output logic [WIDTH-1:0]                       Out_dst_en
);

  localparam int ARCH_REGS = 2**LOG_ARCH;
  localparam int PHYS_REGS = 2**LOG_PHYS;
  localparam int CW        = rn_clog2(WIDTH+1);

  localparam logic [LOG_ARCH-1:0]  ARCH_ZERO   = {LOG_ARCH{1'b0}};
  localparam logic [LOG_PHYS-1:0]  PHYS_ZERO   = {LOG_PHYS{1'b0}};
  localparam logic [PHYS_REGS-1:0] PHYS_BIT0   = {{(PHYS_REGS-1){1'b0}}, 1'b1};

  logic [LOG_PHYS-1:0]       frat_r [ARCH_REGS];
  logic [PHYS_REGS-1:0]      busy_r;
  logic [PHYS_REGS-1:0]      busy_nxt_s;
  logic [PHYS_REGS-1:0]      wb_clr_s;

  logic [WIDTH-1:0]          need_s;
  logic [WIDTH-1:0]          acc_s;
  logic [CW-1:0]             acc_cnt_s;
  logic [CW-1:0]             pop_cnt_s;
  logic [WIDTH*LOG_PHYS-1:0] new_phys_s;

  logic [WIDTH-1:0]          hit_a_s;
  logic [WIDTH-1:0]          hit_b_s;
  logic [WIDTH-1:0]          hit_old_s;
  logic [WIDTH*LOG_PHYS-1:0] byp_a_s;
  logic [WIDTH*LOG_PHYS-1:0] byp_b_s;
  logic [WIDTH*LOG_PHYS-1:0] byp_old_s;

  logic [WIDTH*LOG_PHYS-1:0] sa_phys_s;
  logic [WIDTH*LOG_PHYS-1:0] sb_phys_s;
  logic [WIDTH-1:0]          sa_rdy_s;
  logic [WIDTH-1:0]          sb_rdy_s;
  logic [WIDTH*LOG_PHYS-1:0] dst_phys_s;
  logic [WIDTH*LOG_PHYS-1:0] old_phys_s;
  logic [WIDTH-1:0]          dst_en_s;

  // Destination need: arch reg 0 is never renamed.
  always_comb begin
    need_s = {WIDTH{1'b0}};
    for (int j = 0; j < WIDTH; j++) begin
      need_s[j] = In_regwrite[j] & (In_dst[j*LOG_ARCH +: LOG_ARCH] != ARCH_ZERO);
    end
  end

  // Accept the longest prefix whose cumulative demands fit every resource.
  // Reset and flush start the scan already stopped, so nothing is accepted.
  always_comb begin
    int   need_sum;
    int   mem_sum;
    logic stop;
    logic ok;
    acc_s     = {WIDTH{1'b0}};
    acc_cnt_s = {CW{1'b0}};
    pop_cnt_s = {CW{1'b0}};
    need_sum  = 0;
    mem_sum   = 0;
    stop      = FLUSH | ~RESET;
    ok        = 1'b0;
    for (int p = 0; p < WIDTH; p++) begin
      need_sum = need_sum + int'(need_s[p]);
      mem_sum  = mem_sum + int'(In_mem[p]);
      ok = ~stop & In_valid[p]
           & ((p + 1) <= int'(Rob_free))
           & ((p + 1) <= int'(Iq_free))
           & (need_sum <= int'(Free_count))
           & (mem_sum <= int'(Lsq_free));
      stop      = ~ok;
      acc_s[p]  = ok;
      acc_cnt_s = ok ? CW'(p + 1) : acc_cnt_s;
      pop_cnt_s = ok ? CW'(need_sum) : pop_cnt_s;
    end
  end

  assign Accept_count   = acc_cnt_s;
  assign Free_pop_count = pop_cnt_s;

  // The j-th destination-needing slot takes free-list head j.
  always_comb begin
    int fidx;
    new_phys_s = {(WIDTH*LOG_PHYS){1'b0}};
    fidx       = 0;
    for (int j = 0; j < WIDTH; j++) begin
      new_phys_s[j*LOG_PHYS +: LOG_PHYS] = Free_phys[fidx*LOG_PHYS +: LOG_PHYS];
      fidx = fidx + int'(need_s[j]);
    end
  end

  // One-hot mask of physical registers written back this cycle.
  always_comb begin
    wb_clr_s = {PHYS_REGS{1'b0}};
    for (int w = 0; w < NWB; w++) begin
      wb_clr_s = wb_clr_s | (Wb_valid[w] ? (PHYS_BIT0 << Wb_phys[w*LOG_PHYS +: LOG_PHYS])
                                         : {PHYS_REGS{1'b0}});
    end
  end

  rename_dep_check #(
    .WIDTH    (WIDTH),
    .LOG_ARCH (LOG_ARCH),
    .LOG_PHYS (LOG_PHYS)
  ) u_dep_check (
    .acc_mask   (acc_s),
    .need_mask  (need_s),
    .dst_arch   (In_dst),
    .src_a_arch (In_srcA),
    .src_b_arch (In_srcB),
    .new_phys   (new_phys_s),
    .hit_a      (hit_a_s),
    .hit_b      (hit_b_s),
    .hit_old    (hit_old_s),
    .byp_a      (byp_a_s),
    .byp_b      (byp_b_s),
    .byp_old    (byp_old_s)
  );

  // Per-slot source/old lookup. In-bundle producers are never ready yet;
  // F-RAT mappings are ready unless busy, with a same-cycle writeback
  // counting as ready. Non-accepted slots are driven to zero.
  always_comb begin
    logic [LOG_ARCH-1:0] a_arch;
    logic [LOG_ARCH-1:0] b_arch;
    logic [LOG_ARCH-1:0] d_arch;
    logic [LOG_PHYS-1:0] a_map;
    logic [LOG_PHYS-1:0] b_map;
    sa_phys_s  = {(WIDTH*LOG_PHYS){1'b0}};
    sb_phys_s  = {(WIDTH*LOG_PHYS){1'b0}};
    dst_phys_s = {(WIDTH*LOG_PHYS){1'b0}};
    old_phys_s = {(WIDTH*LOG_PHYS){1'b0}};
    sa_rdy_s   = {WIDTH{1'b0}};
    sb_rdy_s   = {WIDTH{1'b0}};
    dst_en_s   = {WIDTH{1'b0}};
    a_arch     = ARCH_ZERO;
    b_arch     = ARCH_ZERO;
    d_arch     = ARCH_ZERO;
    a_map      = PHYS_ZERO;
    b_map      = PHYS_ZERO;
    for (int j = 0; j < WIDTH; j++) begin
      a_arch = In_srcA[j*LOG_ARCH +: LOG_ARCH];
      b_arch = In_srcB[j*LOG_ARCH +: LOG_ARCH];
      d_arch = In_dst[j*LOG_ARCH +: LOG_ARCH];
      a_map  = frat_r[a_arch];
      b_map  = frat_r[b_arch];
      dst_en_s[j] = acc_s[j] & need_s[j];

      sa_phys_s[j*LOG_PHYS +: LOG_PHYS] =
        (~acc_s[j] | (a_arch == ARCH_ZERO)) ? PHYS_ZERO
        : (hit_a_s[j] ? byp_a_s[j*LOG_PHYS +: LOG_PHYS] : a_map);
      sb_phys_s[j*LOG_PHYS +: LOG_PHYS] =
        (~acc_s[j] | (b_arch == ARCH_ZERO)) ? PHYS_ZERO
        : (hit_b_s[j] ? byp_b_s[j*LOG_PHYS +: LOG_PHYS] : b_map);

      sa_rdy_s[j] = acc_s[j] & ((a_arch == ARCH_ZERO)
                    | (~hit_a_s[j] & (~busy_r[a_map] | wb_clr_s[a_map])));
      sb_rdy_s[j] = acc_s[j] & ((b_arch == ARCH_ZERO)
                    | (~hit_b_s[j] & (~busy_r[b_map] | wb_clr_s[b_map])));

      dst_phys_s[j*LOG_PHYS +: LOG_PHYS] =
        dst_en_s[j] ? new_phys_s[j*LOG_PHYS +: LOG_PHYS] : PHYS_ZERO;
      old_phys_s[j*LOG_PHYS +: LOG_PHYS] =
        ~dst_en_s[j] ? PHYS_ZERO
        : (hit_old_s[j] ? byp_old_s[j*LOG_PHYS +: LOG_PHYS] : frat_r[d_arch]);
    end
  end

  // Busy next-state: writebacks clear first, new allocations set afterwards
  // so an (illegal) same-phys collision resolves to busy.
  always_comb begin
    busy_nxt_s = busy_r & ~wb_clr_s;
    for (int j = 0; j < WIDTH; j++) begin
      busy_nxt_s = busy_nxt_s | (dst_en_s[j] ? (PHYS_BIT0 << new_phys_s[j*LOG_PHYS +: LOG_PHYS])
                                             : {PHYS_REGS{1'b0}});
    end
  end

  // F-RAT and busy table; later slots overwrite earlier ones for the same arch reg.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        frat_r[i] <= LOG_PHYS'(i);
      end
      busy_r <= {PHYS_REGS{1'b0}};
    end else if (FLUSH) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        frat_r[i] <= Commit_map[i*LOG_PHYS +: LOG_PHYS];
      end
      busy_r <= {PHYS_REGS{1'b0}};
    end else begin
      for (int j = 0; j < WIDTH; j++) begin
        if (dst_en_s[j]) begin
          frat_r[In_dst[j*LOG_ARCH +: LOG_ARCH]] <= new_phys_s[j*LOG_PHYS +: LOG_PHYS];
        end
      end
      busy_r <= busy_nxt_s;
    end
  end

  // Registered renamed bundle, valid one cycle after acceptance.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Out_valid     <= {WIDTH{1'b0}};
      Out_srcA_phys <= {(WIDTH*LOG_PHYS){1'b0}};
      Out_srcB_phys <= {(WIDTH*LOG_PHYS){1'b0}};
      Out_srcA_rdy  <= {WIDTH{1'b0}};
      Out_srcB_rdy  <= {WIDTH{1'b0}};
      Out_dst_phys  <= {(WIDTH*LOG_PHYS){1'b0}};
      Out_old_phys  <= {(WIDTH*LOG_PHYS){1'b0}};
      Out_dst_en    <= {WIDTH{1'b0}};
    end else begin
      Out_valid     <= acc_s;
      Out_srcA_phys <= sa_phys_s;
      Out_srcB_phys <= sb_phys_s;
      Out_srcA_rdy  <= sa_rdy_s;
      Out_srcB_rdy  <= sb_rdy_s;
      Out_dst_phys  <= dst_phys_s;
      Out_old_phys  <= old_phys_s;
      Out_dst_en    <= dst_en_s;
    end
  end

endmodule
